// File: rtl/ctrl_seq_monitor_if.sv
// rtl/ctrl_seq_monitor_if.sv - controller strobe bus shared by the controller and its monitor
interface ctrl_seq_monitor_if;
  logic sel;
  logic rd;
  logic ld_ir;
  logic halt;
  logic inc_pc;
  logic ld_ac;
  logic wr;
  logic ld_pc;
  logic data_e;

  modport master (output sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e);
  modport slave  (input  sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e);
endinterface

// File: rtl/ctrl_seq_monitor.sv
// rtl/ctrl_seq_monitor.sv - passive phase tracker, instruction classifier and checker for the controller strobes
module ctrl_seq_monitor #(
  parameter int CNT_W = 16,
  parameter int ERR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  ctrl_seq_monitor_if.slave  bus,
  output logic [2:0]         phase,
  output logic               instr_valid,
  output logic [2:0]         instr_class,
  output logic               halted,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [CNT_W-1:0]   instr_count,
  output logic [ERR_W-1:0]   err_count
);

  // Strobe vector order: {sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e}
  localparam logic [8:0] S_SEL  = 9'h100;
  localparam logic [8:0] S_RD   = 9'h080;
  localparam logic [8:0] S_LDIR = 9'h040;
  localparam logic [8:0] S_HALT = 9'h020;
  localparam logic [8:0] S_INC  = 9'h010;
  localparam logic [8:0] S_LDAC = 9'h008;
  localparam logic [8:0] S_WR   = 9'h004;
  localparam logic [8:0] S_LDPC = 9'h002;
  localparam logic [8:0] S_DATA = 9'h001;

  localparam logic [2:0] G_NONE = 3'd0;
  localparam logic [2:0] G_ALU  = 3'd1;
  localparam logic [2:0] G_INC  = 3'd2;
  localparam logic [2:0] G_JMP  = 3'd3;
  localparam logic [2:0] G_STO  = 3'd4;
  localparam logic [2:0] G_BAD  = 3'd7;

  logic [2:0] exp_ph;
  logic       prev_sel;
  logic       bad;
  logic       sig_halt;
  logic       sig_rd5;
  logic [2:0] sig_p6;

  logic [8:0] s;
  logic       sync;
  logic [2:0] cur;
  logic       bad_in;
  logic       fetch_bad;
  logic       exec_bad;
  logic [2:0] p6;
  logic [2:0] p7;
  logic       sig_ok;
  logic [2:0] cls;
  logic       err_now;
  logic [1:0] code_now;
  logic       good;

  always_comb begin
    s = {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc, bus.ld_ac, bus.wr, bus.ld_pc, bus.data_e};
    sync   = bus.sel && !prev_sel && (exp_ph != 3'd0);
    cur    = sync ? 3'd0 : exp_ph;
    bad_in = (cur == 3'd0) ? 1'b0 : bad;
    fetch_bad = 1'b0;
    exec_bad  = 1'b0;
    p6 = G_NONE;
    p7 = G_NONE;
    case (cur)
      3'd0: fetch_bad = (s != S_SEL);
      3'd1: fetch_bad = (s != (S_SEL | S_RD));
      3'd2, 3'd3: fetch_bad = (s != (S_SEL | S_RD | S_LDIR));
      3'd4: exec_bad = ((s & ~S_HALT) != S_INC);
      3'd5: exec_bad = (s != 9'd0) && (s != S_RD);
      3'd6: begin
        case (s)
          9'd0:          p6 = G_NONE;
          S_RD | S_LDAC: p6 = G_ALU;
          S_INC:         p6 = G_INC;
          S_LDPC:        p6 = G_JMP;
          S_DATA:        p6 = G_STO;
          default: begin
            p6 = G_BAD;
            exec_bad = 1'b1;
          end
        endcase
      end
      default: begin
        case (s)
          9'd0:           p7 = G_NONE;
          S_RD | S_LDAC:  p7 = G_ALU;
          S_INC | S_LDPC: p7 = G_JMP;
          S_WR | S_DATA:  p7 = G_STO;
          default: begin
            p7 = G_BAD;
            exec_bad = 1'b1;
          end
        endcase
      end
    endcase

    // The full signature is only known at the phase-7 sample.
    sig_ok = 1'b0;
    cls    = 3'd0;
    if (sig_halt) begin
      sig_ok = !sig_rd5 && (sig_p6 == G_NONE) && (p7 == G_NONE);
      cls    = 3'd5;
    end else if (sig_rd5) begin
      sig_ok = (sig_p6 == G_ALU) && (p7 == G_ALU);
      cls    = 3'd2;
    end else begin
      case ({sig_p6, p7})
        {G_NONE, G_NONE}: begin sig_ok = 1'b1; cls = 3'd0; end
        {G_INC,  G_NONE}: begin sig_ok = 1'b1; cls = 3'd1; end
        {G_STO,  G_STO }: begin sig_ok = 1'b1; cls = 3'd3; end
        {G_JMP,  G_JMP }: begin sig_ok = 1'b1; cls = 3'd4; end
        default:          begin sig_ok = 1'b0; cls = 3'd0; end
      endcase
    end

    err_now  = 1'b0;
    code_now = 2'd0;
    if (sync) begin
      err_now  = 1'b1;
      code_now = 2'd3;
    end else if (!bad_in && fetch_bad) begin
      err_now  = 1'b1;
      code_now = 2'd1;
    end else if (!bad_in && (exec_bad || ((cur == 3'd7) && !sig_ok))) begin
      err_now  = 1'b1;
      code_now = 2'd2;
    end
    good = (cur == 3'd7) && !bad_in && !exec_bad && sig_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_ph      <= 3'd0;
      prev_sel    <= 1'b0;
      bad         <= 1'b0;
      sig_halt    <= 1'b0;
      sig_rd5     <= 1'b0;
      sig_p6      <= G_NONE;
      phase       <= 3'd0;
      instr_valid <= 1'b0;
      instr_class <= 3'd0;
      halted      <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'd0;
      instr_count <= '0;
      err_count   <= '0;
    end else begin
      phase    <= cur;
      exp_ph   <= cur + 3'd1;
      prev_sel <= bus.sel;
      // A resync opens a fresh instruction, so its own SYNC report does not taint it.
      bad      <= sync ? 1'b0 : (bad_in | err_now);
      if (cur == 3'd4) begin
        sig_halt <= bus.halt;
        if (bus.halt) halted <= 1'b1;
      end
      if (cur == 3'd5) sig_rd5 <= bus.rd;
      if (cur == 3'd6) sig_p6 <= p6;
      err         <= err_now;
      err_code    <= code_now;
      instr_valid <= good;
      if (good) begin
        instr_class <= cls;
        instr_count <= instr_count + CNT_W'(1);
      end
      if (err_now && (err_count != {ERR_W{1'b1}})) err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_seq_monitor.sv
// tb/tb_ctrl_seq_monitor.sv - directed self-checking bench for ctrl_seq_monitor
module tb_ctrl_seq_monitor;
  localparam logic [8:0] B_SEL  = 9'h100;
  localparam logic [8:0] B_RD   = 9'h080;
  localparam logic [8:0] B_LDIR = 9'h040;
  localparam logic [8:0] B_HALT = 9'h020;
  localparam logic [8:0] B_INC  = 9'h010;
  localparam logic [8:0] B_LDAC = 9'h008;
  localparam logic [8:0] B_WR   = 9'h004;
  localparam logic [8:0] B_LDPC = 9'h002;
  localparam logic [8:0] B_DATA = 9'h001;
  localparam logic [8:0] F0 = B_SEL;
  localparam logic [8:0] F1 = B_SEL | B_RD;
  localparam logic [8:0] F2 = B_SEL | B_RD | B_LDIR;

  logic        clk;
  logic        reset;
  logic [2:0]  phase;
  logic        instr_valid;
  logic [2:0]  instr_class;
  logic        halted;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] instr_count;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_fail = 0;
  int exp_icnt = 0;
  int exp_ecnt = 0;
  bit exp_halted = 0;

  ctrl_seq_monitor_if bus ();

  ctrl_seq_monitor #(.CNT_W(16), .ERR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .phase       (phase),
    .instr_valid (instr_valid),
    .instr_class (instr_class),
    .halted      (halted),
    .err         (err),
    .err_code    (err_code),
    .instr_count (instr_count),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [8:0] s);
    {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc, bus.ld_ac, bus.wr, bus.ld_pc, bus.data_e} = s;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [8:0] s, input int ph, input bit e, input logic [1:0] code,
                      input bit v, input logic [2:0] cls);
    tick(s);
    if (e && exp_ecnt < 255) exp_ecnt++;
    if (v) exp_icnt++;
    if (ph == 4 && s[5]) exp_halted = 1'b1;
    chk("phase", phase, ph);
    chk("err", err, e);
    if (e) chk("err_code", err_code, code);
    chk("instr_valid", instr_valid, v);
    if (v) chk("instr_class", instr_class, cls);
    chk("instr_count", instr_count, exp_icnt);
    chk("err_count", err_count, exp_ecnt);
    chk("halted", halted, exp_halted);
  endtask

  task automatic instr(input logic [8:0] e4, input logic [8:0] e5, input logic [8:0] e6,
                       input logic [8:0] e7, input logic [2:0] cls, input int bad_ph, input int from);
    logic [8:0] v [8];
    v = '{F0, F1, F2, F2, e4, e5, e6, e7};
    for (int i = from; i < 8; i++)
      step(v[i], i, i == bad_ph, (bad_ph < 4) ? 2'd1 : 2'd2, (i == 7) && (bad_ph < 0), cls);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(9'd0);
    reset = 1'b0;
    exp_icnt = 0;
    exp_ecnt = 0;
    exp_halted = 1'b0;
    chk("rst_phase", phase, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_class", instr_class, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_instr_count", instr_count, 0);
    chk("rst_err_count", err_count, 0);
  endtask

  initial begin
    reset = 1'b1;
    {bus.sel, bus.rd, bus.ld_ir, bus.halt, bus.inc_pc, bus.ld_ac, bus.wr, bus.ld_pc, bus.data_e} = 9'd0;
    do_reset();

    // ADD, then STO and JMP back to back
    instr(B_INC, B_RD, B_RD | B_LDAC, B_RD | B_LDAC, 3'd2, -1, 0);
    instr(B_INC, 9'd0, B_DATA, B_WR | B_DATA, 3'd3, -1, 0);
    instr(B_INC, 9'd0, B_LDPC, B_INC | B_LDPC, 3'd4, -1, 0);

    // SKZ taken, SKZ not taken
    instr(B_INC, 9'd0, B_INC, 9'd0, 3'd1, -1, 0);
    instr(B_INC, 9'd0, 9'd0, 9'd0, 3'd0, -1, 0);

    // HLT, halted survives a following ADD, cleared by reset
    instr(B_INC | B_HALT, 9'd0, 9'd0, 9'd0, 3'd5, -1, 0);
    instr(B_INC, B_RD, B_RD | B_LDAC, B_RD | B_LDAC, 3'd2, -1, 0);
    do_reset();

    // ADD with wr in phase 6: one EXEC error, no pulse; next ADD is clean
    instr(B_INC, B_RD, B_RD | B_LDAC | B_WR, B_RD | B_LDAC, 3'd2, 6, 0);
    instr(B_INC, B_RD, B_RD | B_LDAC, B_RD | B_LDAC, 3'd2, -1, 0);

    // Illegal phase-7 combination on a JMP
    instr(B_INC, 9'd0, B_LDPC, B_LDPC | B_WR, 3'd4, 7, 0);
    // HLT with phase-5 activity is an EXEC error at the phase-7 sample
    instr(B_INC | B_HALT, B_RD, 9'd0, 9'd0, 3'd5, 7, 0);

    // FETCH error at phase 0, suppressed repeat, SYNC at counter phase 2, then ADD
    step(9'd0, 0, 1'b1, 2'd1, 1'b0, 3'd0);
    step(9'd0, 1, 1'b0, 2'd0, 1'b0, 3'd0);
    step(B_SEL, 0, 1'b1, 2'd3, 1'b0, 3'd0);
    instr(B_INC, B_RD, B_RD | B_LDAC, B_RD | B_LDAC, 3'd2, -1, 1);

    // Every alternating sample raises FETCH or SYNC: 300 errors saturate
    for (int i = 0; i < 300; i++) tick((i % 2 == 1) ? B_SEL : 9'd0);
    chk("sat_err_count", err_count, 255);
    chk("sat_err", err, 1);
    chk("sat_err_code", err_code, 3);
    chk("sat_phase", phase, 0);
    chk("sat_instr_count", instr_count, exp_icnt);

    // Reset in mid-instruction drops it; counting restarts
    do_reset();
    tick(F0);
    tick(F1);
    tick(F2);
    tick(F2);
    tick(B_INC);
    do_reset();
    instr(B_INC, B_RD, B_RD | B_LDAC, B_RD | B_LDAC, 3'd2, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ctrl_seq_monitor.md
# ctrl_seq_monitor

Passive decoder/checker on the controller's strobe bus; it is the receiving end of the controller's eight-phase control protocol. From `sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e` alone it:
- recovers the controller phase;
- classifies each completed instruction;
- counts instructions;
- flags protocol violations.

It sits beside the controller in the CPU top level and in benches, and drives nothing back into the datapath.

## Interface
Parameters:
- `CNT_W`, default 16: width of `instr_count`.
- `ERR_W`, default 8: width of `err_count`.

Ports:
- `clk`  in  1  single clock; all strobes are sampled on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge.
- `sel, rd, ld_ir, halt, inc_pc, ld_ac, wr, ld_pc, data_e`  in  1 each  controller strobes, sampled every cycle.
- `phase`  out  3  phase of the strobe sample currently being checked.
- `instr_valid`  out  1  one-cycle pulse; `instr_class` is valid.
- `instr_class`  out  3  class codes:
  - 0 SKZ not taken
  - 1 SKZ taken
  - 2 ALU op (ADD/AND/XOR/LDA)
  - 3 STO
  - 4 JMP
  - 5 HLT
- `halted`  out  1  sticky; set once `halt` has been seen.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  valid when `err`=1:
  - 1 FETCH
  - 2 EXEC
  - 3 SYNC
- `instr_count`  out  CNT_W  classified instructions; wraps modulo 2^CNT_W.
- `err_count`  out  ERR_W  errors; saturates at all-ones.

## Operation
Expected strobe pattern per phase. Any strobe not listed must be 0.
- Phase 0: `sel`.
- Phase 1: `sel, rd`.
- Phases 2 and 3: `sel, rd, ld_ir`.
- Phase 4: `inc_pc`; `halt` optional.
- Phase 5: `rd` optional.
- Phase 6, exactly one of these or none:
  - `rd+ld_ac`
  - `inc_pc`
  - `ld_pc`
  - `data_e`
- Phase 7, exactly one of these or none:
  - `rd+ld_ac`
  - `inc_pc+ld_pc`
  - `wr+data_e`

Phase tracking:
- Phase counter increments every cycle and wraps 7→0.
- Resync: `sel`=1 with previous-cycle `sel`=0 while the counter is not 0:
  - current sample is treated as phase 0;
  - `err_code`=3 (SYNC);
  - the in-flight instruction is discarded.
- A SYNC event suppresses a simultaneous FETCH check.

Per-instruction signature, accumulated over phases 4–7:
- `halt` in phase 4 → HLT; sets `halted`.
- `rd` in phase 5, `rd+ld_ac` in phases 6 and 7 → ALU.
- `inc_pc` in phase 6 only → SKZ taken.
- `data_e` in phase 6, `wr+data_e` in phase 7 → STO.
- `ld_pc` in phase 6, `inc_pc+ld_pc` in phase 7 → JMP.
- No strobes in phases 5–7 and no halt → SKZ not taken.

Errors:
- Any deviation in phases 0–3 → FETCH (code 1).
- Any of these in phases 4–7 → EXEC (code 2):
  - an illegal combination;
  - a signature that does not match exactly one class;
  - `halt` together with phase 5–7 activity.
- At most one error per cycle. Priority: SYNC > FETCH > EXEC.
- Every error increments `err_count`.
- Only one error is reported per instruction. The first error marks the instruction bad; later mismatches in the same instruction are not reported.

Classification at the phase-7 sample:
- Good instruction: `instr_valid`=1, `instr_class` updated, `instr_count`+1.
- Bad instruction: `instr_valid` stays 0 and `instr_count` is unchanged.

Other rules:
- `halted` is cleared only by `reset`. The monitor keeps decoding after a halt.

## Timing
Reset, on the clock edge with `reset`=1:
- `phase`=0, `instr_valid`=0, `instr_class`=0, `halted`=0, `err`=0, `err_code`=0, `instr_count`=0, `err_count`=0.
- Previous-`sel` register=0.
- The controller is reset on the same edge, so the first post-reset sample is phase 0.

Output registration and latency:
- All outputs are registered.
- `err`/`err_code` appear one cycle after the offending sample.
- `instr_valid` appears one cycle after the phase-7 sample.
- `instr_count`/`err_count` update in the same cycle as their pulse.
- `halted` rises one cycle after the phase-4 sample carrying `halt`.

Other timing rules:
- `phase` output equals the phase assigned to the sample taken on the same edge, i.e. phase after resync correction.
- Back-to-back instructions: `instr_valid` every 8 cycles, no gaps.
- Reset asserted mid-instruction: the partial instruction is dropped with no pulse; counters clear.
- Reset has priority over all events.

## Test plan
- Reset, drive ADD strobe sequence for 8 cycles → `instr_valid` at cycle 8, class=2, `instr_count`=1, `err`=0.
- STO then JMP back-to-back → class 3 then class 4, pulses 8 cycles apart, `instr_count`=2.
- SKZ with `inc_pc` in phase 6, then SKZ with no phase-6 strobe → classes 1 then 0, no errors.
- HLT (`halt` in phase 4) → `halted`=1 one cycle later, class=5; `halted` stays 1 through a following ADD and clears on `reset`.
- ADD with `wr` forced high in phase 6 → single `err`, code 2, `err_count`=1, no `instr_valid` for that instruction; next ADD classified normally.
- Rising `sel` injected at counter phase 2 → `err` code 3, `phase` re-aligned to 0, next full ADD gives class=2; 300 errors saturate `err_count` at 255.
